// File: rtl/io_map_pkg.sv
// Board I/O memory map and switch-conditioning defaults shared by the data
// memory, the address decode and the switch debouncer.
package io_map_pkg;

  localparam logic [31:0] SW_ADDR  = 32'h90;
  localparam logic [31:0] LED_ADDR = 32'h94;

  localparam int SW_WIDTH = 8;

  // 10 ms settle time on the 50 MHz board clock.
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  function automatic int debounce_cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw pins and CPU ack in, clean level, edge pulses
// and sticky change flag out.
interface switch_debouncer_if
  import io_map_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic             ack;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             change_irq;

  modport master (
    output sw_raw,
    output ack,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  change_irq
  );

  modport slave (
    input  sw_raw,
    input  ack,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output change_irq
  );

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer chain, mismatch counter and the accepted level
// with its registered rise/fall pulses.
module debounce_bit
  import io_map_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall,
  output logic accept
);

  localparam int                CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   stable_reg;
  logic                   stable_next;
  logic                   rise_reg;
  logic                   rise_next;
  logic                   fall_reg;
  logic                   fall_next;
  logic                   sync_bit;

  assign sync_bit = sync_reg[SYNC_STAGES-1];

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreeing cycle throws the partial count away.
  always_comb begin
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    accept      = 1'b0;
    if (sync_bit == stable_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      accept      = 1'b1;
      cnt_next    = '0;
      stable_next = sync_bit;
      rise_next   = sync_bit;
      fall_next   = ~sync_bit;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg   <= '0;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sw_raw};
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  assign sw_stable = stable_reg;
  assign sw_rise   = rise_reg;
  assign sw_fall   = fall_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the slide-switch vector bit by bit and raises a sticky change
// flag that the CPU clears with ack when it reads the switch port.
module switch_debouncer
  import io_map_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_debouncer_if.slave bus
);

  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] accept_vec;
  logic             change_irq_reg;
  logic             change_irq_next;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_raw    (bus.sw_raw[gi]),
      .sw_stable (stable_vec[gi]),
      .sw_rise   (rise_vec[gi]),
      .sw_fall   (fall_vec[gi]),
      .accept    (accept_vec[gi])
    );
  end

  // A new acceptance beats a simultaneous ack so no change is ever lost.
  always_comb begin
    change_irq_next = change_irq_reg;
    if (|accept_vec) begin
      change_irq_next = 1'b1;
    end else if (bus.ack) begin
      change_irq_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      change_irq_reg <= 1'b0;
    end else begin
      change_irq_reg <= change_irq_next;
    end
  end

  assign bus.sw_stable  = stable_vec;
  assign bus.sw_rise    = rise_vec;
  assign bus.sw_fall    = fall_vec;
  assign bus.change_irq = change_irq_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scenario bench for switch_debouncer with a short debounce window; a
// window-based reference model shadows every clock edge.
module tb_switch_debouncer;

  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W)) bus ();

  switch_debouncer #(
    .WIDTH           (W),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: a level is accepted once the last D synchronized
  // samples (since reset) all disagree with the current accepted level.
  logic [W-1:0] pipe_q[$];
  logic [W-1:0] hist_q[$];
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  logic         m_irq = 1'b0;

  task automatic model_edge();
    logic [W-1:0] s;
    logic         any_change;
    bit           all_diff;
    if (!rst_n) begin
      pipe_q.delete();
      for (int k = 0; k < S; k++) pipe_q.push_back('0);
      hist_q.delete();
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_irq    = 1'b0;
    end else begin
      s = pipe_q.pop_front();
      pipe_q.push_back(bus.sw_raw);
      hist_q.push_back(s);
      if (hist_q.size() > D) void'(hist_q.pop_front());
      m_rise = '0;
      m_fall = '0;
      any_change = 1'b0;
      if (hist_q.size() == D) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++) if (hist_q[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            if (m_stable[i]) m_rise[i] = 1'b1;
            else             m_fall[i] = 1'b1;
            any_change = 1'b1;
          end
        end
      end
      if (any_change)    m_irq = 1'b1;
      else if (bus.ack)  m_irq = 1'b0;
    end
  endtask

  // Inputs change only at negedge, so the model sees what the DUT samples.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] e_st, e_r;
    logic         e_irq;
    rst_n = 1'b0;
    bus.sw_raw = 8'hFF;
    bus.ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== 25'd0) begin
        n_err++;
        $display("FAIL reset_hold c=%0d got st=%h r=%h f=%h irq=%b want all 0", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      e_st  = (c >= 6) ? 8'hFF : 8'h00;
      e_r   = (c == 6) ? 8'hFF : 8'h00;
      e_irq = (c >= 6);
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== {e_st, e_r, 8'h00, e_irq}) begin
        n_err++;
        $display("FAIL powerup c=%0d got st=%h r=%h f=%h irq=%b want st=%h r=%h f=00 irq=%b", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq, e_st, e_r, e_irq);
      end
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++;
    if (bus.change_irq !== 1'b0) begin
      n_err++;
      $display("FAIL ack_clear got irq=%b want 0", bus.change_irq);
    end
    $display("test_reset done: %0d compared so far", n_cmp);
  endtask

  task automatic test_glitch();
    bus.sw_raw = 8'h00;
    for (int c = 0; c < 8; c++) step();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    step();
    for (int c = 0; c < 13; c++) begin
      bus.sw_raw = (c < 3) ? 8'h01 : 8'h00;
      step();
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.change_irq} !== 17'd0 ||
          {bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== {m_stable, m_rise, m_fall, m_irq}) begin
        n_err++;
        $display("FAIL glitch c=%0d got st=%h r=%h irq=%b want st=00 r=00 irq=0", c,
                 bus.sw_stable, bus.sw_rise, bus.change_irq);
      end
    end
    $display("test_glitch done: %0d compared so far", n_cmp);
  endtask

  task automatic test_rise_fall();
    logic [W-1:0] e_st, e_p;
    bus.sw_raw = 8'h05;
    for (int c = 1; c <= 7; c++) begin
      step();
      e_st = (c >= 6) ? 8'h05 : 8'h00;
      e_p  = (c == 6) ? 8'h05 : 8'h00;
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== {e_st, e_p, 8'h00, (c >= 6)}) begin
        n_err++;
        $display("FAIL rise05 c=%0d got st=%h r=%h f=%h irq=%b want st=%h r=%h f=00", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq, e_st, e_p);
      end
    end
    bus.sw_raw = 8'h00;
    for (int c = 1; c <= 7; c++) begin
      step();
      e_st = (c >= 6) ? 8'h00 : 8'h05;
      e_p  = (c == 6) ? 8'h05 : 8'h00;
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall} !== {e_st, 8'h00, e_p}) begin
        n_err++;
        $display("FAIL fall05 c=%0d got st=%h r=%h f=%h want st=%h r=00 f=%h", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, e_st, e_p);
      end
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    $display("test_rise_fall done: %0d compared so far", n_cmp);
  endtask

  task automatic test_ack_collision();
    bus.sw_raw = 8'h10;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_cmp++;
      if (bus.change_irq !== 1'b0 || bus.sw_stable !== 8'h00) begin
        n_err++;
        $display("FAIL ack_pre c=%0d got st=%h irq=%b want st=00 irq=0", c, bus.sw_stable, bus.change_irq);
      end
    end
    bus.ack = 1'b1;
    step();
    n_cmp++;
    if (bus.change_irq !== 1'b1 || bus.sw_stable !== 8'h10) begin
      n_err++;
      $display("FAIL ack_vs_set got st=%h irq=%b want st=10 irq=1", bus.sw_stable, bus.change_irq);
    end
    step();
    bus.ack = 1'b0;
    n_cmp++;
    if (bus.change_irq !== 1'b0) begin
      n_err++;
      $display("FAIL lone_ack got irq=%b want 0", bus.change_irq);
    end
    step();
    n_cmp++;
    if (bus.change_irq !== 1'b0) begin
      n_err++;
      $display("FAIL ack_idle got irq=%b want 0", bus.change_irq);
    end
    $display("test_ack_collision done: %0d compared so far", n_cmp);
  endtask

  task automatic test_toggle();
    int n_rise = 0;
    int rise_at = -1;
    bus.sw_raw = 8'h00;
    for (int c = 0; c < 8; c++) step();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.sw_raw = (((c / 2) % 2) == 0) ? 8'h08 : 8'h00;
      step();
      if (bus.sw_rise[3]) n_rise++;
    end
    bus.sw_raw = 8'h08;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.sw_rise[3]) begin
        n_rise++;
        rise_at = c;
      end
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== {m_stable, m_rise, m_fall, m_irq}) begin
        n_err++;
        $display("FAIL toggle_model c=%0d got st=%h r=%h f=%h irq=%b want st=%h r=%h f=%h irq=%b", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq, m_stable, m_rise, m_fall, m_irq);
      end
    end
    n_cmp++;
    if (n_rise != 1 || rise_at != 6) begin
      n_err++;
      $display("FAIL toggle_rise got count=%0d at=%0d want count=1 at=6", n_rise, rise_at);
    end
    $display("test_toggle done: %0d compared so far", n_cmp);
  endtask

  task automatic test_random();
    logic [W-1:0] raw = bus.sw_raw;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
      bus.sw_raw = raw;
      bus.ack = ($urandom_range(0, 3) == 0);
      step();
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== {m_stable, m_rise, m_fall, m_irq}) begin
        n_err++;
        $display("FAIL random c=%0d got st=%h r=%h f=%h irq=%b want st=%h r=%h f=%h irq=%b", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq, m_stable, m_rise, m_fall, m_irq);
      end
    end
    bus.ack = 1'b0;
    $display("test_random done: %0d compared so far", n_cmp);
  endtask

  task automatic test_reset_midcount();
    logic [W-1:0] e_st, e_r;
    bus.sw_raw = 8'h80;
    for (int c = 0; c < 4; c++) step();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== 25'd0) begin
        n_err++;
        $display("FAIL midreset_hold c=%0d got st=%h r=%h f=%h irq=%b want all 0", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      e_st = (c >= 6) ? 8'h80 : 8'h00;
      e_r  = (c == 6) ? 8'h80 : 8'h00;
      n_cmp++;
      if ({bus.sw_stable, bus.sw_rise, bus.change_irq} !== {e_st, e_r, (c >= 6)} ||
          {bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.change_irq} !== {m_stable, m_rise, m_fall, m_irq}) begin
        n_err++;
        $display("FAIL midreset c=%0d got st=%h r=%h irq=%b want st=%h r=%h irq=%b", c,
                 bus.sw_stable, bus.sw_rise, bus.change_irq, e_st, e_r, (c >= 6));
      end
    end
    $display("test_reset_midcount done: %0d compared so far", n_cmp);
  endtask

  initial begin
    bus.sw_raw = 8'hFF;
    bus.ack = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_glitch();
    test_rise_fall();
    test_ack_collision();
    test_toggle();
    test_random();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
